// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path.
// Holds opcode and branch-condition encodings, PSR flag positions, IR field
// positions and the sequencer state type.
package cpu_pkg;

  // Opcodes, ir[31:28]
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_BRANCH = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_ADD    = 4'h5;
  localparam logic [3:0] OP_ROT    = 4'h6;
  localparam logic [3:0] OP_SHIFT  = 4'h7;
  localparam logic [3:0] OP_HALT   = 4'h8;
  localparam logic [3:0] OP_CMP    = 4'h9;

  // Branch condition codes, ir[14:12]
  localparam logic [2:0] BR_ALWAYS = 3'd0;
  localparam logic [2:0] BR_PAR    = 3'd1;
  localparam logic [2:0] BR_EVEN   = 3'd2;
  localparam logic [2:0] BR_CARRY  = 3'd3;
  localparam logic [2:0] BR_NEG    = 3'd4;
  localparam logic [2:0] BR_ZERO   = 3'd5;
  localparam logic [2:0] BR_NCARRY = 3'd6;
  localparam logic [2:0] BR_POS    = 3'd7;

  // PSR flag bit indices
  localparam int unsigned PSR_W = 5;
  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_P = 1;
  localparam int unsigned PSR_E = 2;
  localparam int unsigned PSR_N = 3;
  localparam int unsigned PSR_Z = 4;

  // IR field positions
  localparam int unsigned IR_OP_HI  = 31;
  localparam int unsigned IR_OP_LO  = 28;
  localparam int unsigned IR_IMM    = 27;
  localparam int unsigned IR_LDA_HI = 23;
  localparam int unsigned IR_LDA_LO = 12;
  localparam int unsigned IR_BR_HI  = 14;
  localparam int unsigned IR_BR_LO  = 12;
  localparam int unsigned IR_TGT_HI = 11;
  localparam int unsigned IR_TGT_LO = 0;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StMemRd,
    StMemWr,
    StHalted
  } seq_state_t;

endpackage

// File: rtl/branch_eval.sv
// Combinational branch condition resolver.
// Ports:
//   psr_i   - datapath flags (carry, parity, even, negative, zero)
//   code_i  - 3-bit branch condition code
//   taken_o - 1 when the condition holds for psr_i
module branch_eval
  import cpu_pkg::*;
(
  input  logic [PSR_W-1:0] psr_i,
  input  logic [2:0]       code_i,
  output logic             taken_o
);

  always_comb begin
    taken_o = 1'b0;
    unique case (code_i)
      BR_ALWAYS: taken_o = 1'b1;
      BR_PAR:    taken_o = psr_i[PSR_P];
      BR_EVEN:   taken_o = psr_i[PSR_E];
      BR_CARRY:  taken_o = psr_i[PSR_C];
      BR_NEG:    taken_o = psr_i[PSR_N];
      BR_ZERO:   taken_o = psr_i[PSR_Z];
      BR_NCARRY: taken_o = ~psr_i[PSR_C];
      BR_POS:    taken_o = ~psr_i[PSR_N];
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the accumulator CPU.
// Owns PC and IR, drives the single req/ack memory port, resolves branches
// and emits one-cycle enables to the datapath.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   mem_req/we/addr/wdata   - memory request, held stable until mem_ack
//   mem_rdata, mem_ack      - read data and completion from memory
//   ir, pc                  - current instruction and next fetch address
//   psr, st_data            - flags and store operand from the datapath
//   exec_en, ld_en, ld_data - execute pulse, load-writeback pulse and data
//   halted, illegal_op      - halt status and undefined-opcode pulse
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 12,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  input  logic [PSR_W-1:0]  psr,
  input  logic [DATA_W-1:0] st_data,
  output logic              exec_en,
  output logic              ld_en,
  output logic [DATA_W-1:0] ld_data,
  output logic              halted,
  output logic              illegal_op
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              ld_en_q, ld_en_d;
  logic              br_taken;

  branch_eval u_branch_eval (
    .psr_i   (psr),
    .code_i  (ir_q[IR_BR_HI:IR_BR_LO]),
    .taken_o (br_taken)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      ld_data_q <= '0;
      ld_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ld_data_q <= ld_data_d;
      ld_en_q   <= ld_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ld_data_d  = ld_data_q;
    ld_en_d    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc_q;
    exec_en    = 1'b0;
    illegal_op = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StDecode;
        end
      end

      StDecode: begin
        state_d = StFetch;
        case (ir_q[IR_OP_HI:IR_OP_LO])
          OP_NOP: ;
          OP_LOAD: begin
            // Immediate loads are handled entirely by the datapath.
            if (ir_q[IR_IMM]) exec_en = 1'b1;
            else              state_d = StMemRd;
          end
          OP_STORE:  state_d = StMemWr;
          OP_BRANCH: if (br_taken) pc_d = ADDR_W'(ir_q[IR_TGT_HI:IR_TGT_LO]);
          OP_XOR, OP_ADD, OP_ROT, OP_SHIFT, OP_CMP: exec_en = 1'b1;
          OP_HALT:   state_d = StHalted;
          default:   illegal_op = 1'b1;
        endcase
      end

      StMemRd: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(ir_q[IR_LDA_HI:IR_LDA_LO]);
        if (mem_ack) begin
          ld_data_d = mem_rdata;
          ld_en_d   = 1'b1;
          state_d   = StFetch;
        end
      end

      StMemWr: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = ADDR_W'(ir_q[IR_TGT_HI:IR_TGT_LO]);
        if (mem_ack) state_d = StFetch;
      end

      StHalted: ;

      default: state_d = StFetch;
    endcase

    // Reset aborts any transaction immediately, not at the next edge.
    if (reset) begin
      mem_req    = 1'b0;
      exec_en    = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign mem_wdata = st_data;
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign ld_data   = ld_data_q;
  assign ld_en     = ld_en_q & ~reset;
  assign halted    = (state_q == StHalted) & ~reset;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus randomized
// programs compared against an instruction-level reference model.
module tb_cpu_sequencer;

  typedef struct packed {
    logic [2:0]  kind;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  localparam logic [2:0] EV_RD  = 3'd1;
  localparam logic [2:0] EV_WR  = 3'd2;
  localparam logic [2:0] EV_EX  = 3'd3;
  localparam logic [2:0] EV_LD  = 3'd4;
  localparam logic [2:0] EV_IL  = 3'd5;
  localparam logic [2:0] EV_HLT = 3'd6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata, ir, st_data, ld_data;
  logic [4:0]  psr;
  logic        exec_en, ld_en, halted, illegal_op;

  cpu_sequencer #(
    .ADDR_W   (12),
    .DATA_W   (32),
    .RESET_PC (12'h000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .ir         (ir),
    .pc         (pc),
    .psr        (psr),
    .st_data    (st_data),
    .exec_en    (exec_en),
    .ld_en      (ld_en),
    .ld_data    (ld_data),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  always #5 clock = ~clock;

  // Memory image, store overlay (valid when stamped with the current generation)
  logic [31:0] mem    [4096];
  logic [31:0] wmem   [4096];
  int          wgen_a [4096];
  int          wgen = 1;
  logic [31:0] mm     [4096];
  logic [31:0] regs   [16];
  logic [4:0]  psr_tab[64];

  int   exec_cnt = 0;
  bit   psr_force_en = 1'b1;
  logic [4:0] psr_force = '0;
  bit   rand_delay = 1'b0;
  int   fixed_delay = 0;
  bit   ack_block = 1'b0;
  bit   force_ack = 1'b0;
  int   wait_cnt = 0;
  int   cur_delay = 0;
  bit   halted_prev = 1'b0;
  bit   rst_seen = 1'b0;

  ev_t act_q[$];
  ev_t exp_q[$];

  // Datapath stand-in: flags advance with every executed instruction.
  assign psr     = psr_force_en ? psr_force : psr_tab[exec_cnt[5:0]];
  assign st_data = regs[ir[15:12]];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk_ev(logic [2:0] k, logic [11:0] a, logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  function automatic logic [31:0] rd_word(logic [11:0] a);
    return (wgen_a[a] == wgen) ? wmem[a] : mem[a];
  endfunction

  function automatic int pick_delay();
    return rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
  endfunction

  // Memory responder and event monitor; samples 3 time units before each posedge.
  initial begin : mem_model
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_rdata = rd_word(mem_addr);
      mem_ack   = force_ack | (!reset && mem_req && !ack_block && (wait_cnt >= cur_delay));
      #2;
      if (reset) begin
        if (!rst_seen) wgen++;
        rst_seen    = 1'b1;
        wait_cnt    = 0;
        cur_delay   = pick_delay();
        exec_cnt    = 0;
        halted_prev = 1'b0;
        act_q.delete();
      end else begin
        rst_seen = 1'b0;
        if (ld_en) act_q.push_back(mk_ev(EV_LD, 12'h0, ld_data));
        if (exec_en) begin
          act_q.push_back(mk_ev(EV_EX, 12'h0, ir));
          exec_cnt++;
        end
        if (illegal_op) act_q.push_back(mk_ev(EV_IL, 12'h0, ir));
        if (halted && !halted_prev) act_q.push_back(mk_ev(EV_HLT, 12'h0, 32'h0));
        halted_prev = halted;
        if (mem_req && mem_ack) begin
          if (mem_we) begin
            act_q.push_back(mk_ev(EV_WR, mem_addr, mem_wdata));
            wmem[mem_addr]   = mem_wdata;
            wgen_a[mem_addr] = wgen;
          end else begin
            act_q.push_back(mk_ev(EV_RD, mem_addr, mem_rdata));
          end
          wait_cnt  = 0;
          cur_delay = pick_delay();
        end else if (mem_req) begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Two reset cycles, then release; returns inside the first FETCH cycle.
  task automatic start();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  function automatic bit br_ref(logic [2:0] c, logic [4:0] p);
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return p[1];
      3'd2:    return p[2];
      3'd3:    return p[0];
      3'd4:    return p[3];
      3'd5:    return p[4];
      3'd6:    return !p[0];
      default: return !p[3];
    endcase
  endfunction

  // Instruction-level model: the architectural event trace of k instructions.
  task automatic build_expected(input int k);
    logic [11:0] mpc;
    logic [11:0] a;
    logic [31:0] ins;
    logic [31:0] d;
    int          ec;
    mpc = 12'h000;
    ec  = 0;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) mm[i] = mem[i];
    for (int i = 0; i < k; i++) begin
      ins = mm[mpc];
      exp_q.push_back(mk_ev(EV_RD, mpc, ins));
      mpc = mpc + 12'd1;
      case (ins[31:28])
        4'h0: ;
        4'h1: begin
          if (ins[27]) begin
            exp_q.push_back(mk_ev(EV_EX, 12'h0, ins));
            ec++;
          end else begin
            a = ins[23:12];
            exp_q.push_back(mk_ev(EV_RD, a, mm[a]));
            exp_q.push_back(mk_ev(EV_LD, 12'h0, mm[a]));
          end
        end
        4'h2: begin
          a = ins[11:0];
          d = regs[ins[15:12]];
          exp_q.push_back(mk_ev(EV_WR, a, d));
          mm[a] = d;
        end
        4'h3: if (br_ref(ins[14:12], psr_tab[ec % 64])) mpc = ins[11:0];
        4'h4, 4'h5, 4'h6, 4'h7, 4'h9: begin
          exp_q.push_back(mk_ev(EV_EX, 12'h0, ins));
          ec++;
        end
        4'h8: begin
          exp_q.push_back(mk_ev(EV_HLT, 12'h0, 32'h0));
          return;
        end
        default: exp_q.push_back(mk_ev(EV_IL, 12'h0, ins));
      endcase
    end
  endtask

  task automatic gen_program();
    logic [3:0] alu_ops [5];
    int r;
    alu_ops = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h9};
    clear_mem();
    for (int i = 12'h100; i < 12'h200; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    for (int i = 0; i < 64; i++) psr_tab[i] = 5'($urandom);
    for (int a = 0; a < 64; a++) begin
      r = int'($urandom_range(0, 31));
      if (r == 0 || r == 31) mem[a] = {4'h0, 28'($urandom)};
      else if (r <= 4)  mem[a] = {4'h1, 1'($urandom), 3'($urandom),
                                  12'h100 | 12'($urandom_range(0, 255)), 12'($urandom)};
      else if (r <= 8)  mem[a] = {4'h2, 12'($urandom), 4'($urandom),
                                  12'h100 | 12'($urandom_range(0, 255))};
      else if (r <= 15) mem[a] = {4'h3, 13'($urandom), 3'($urandom), 6'h0, 6'($urandom)};
      else if (r <= 26) mem[a] = {alu_ops[$urandom_range(0, 4)], 28'($urandom)};
      else if (r <= 29) mem[a] = {4'($urandom_range(10, 15)), 28'($urandom)};
      else              mem[a] = {4'h8, 28'($urandom)};
    end
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    int cyc;
    int cnt;
    logic [31:0] ins;
    logic [11:0] exp_pc;

    for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[7] = 32'h1234_5678;
    for (int i = 0; i < 64; i++) psr_tab[i] = '0;
    clear_mem();

    // Reset values and first fetch
    reset = 1'b1;
    step();
    step();
    check_eq("rst_pc", 64'(pc), 64'h000);
    check_eq("rst_ir", 64'(ir), 64'h0);
    check_eq("rst_ld_data", 64'(ld_data), 64'h0);
    check_eq("rst_mem_req", 64'(mem_req), 64'h0);
    check_eq("rst_halted", 64'(halted), 64'h0);
    check_eq("rst_pulses", 64'({exec_en, ld_en, illegal_op}), 64'h0);
    reset = 1'b0;
    #1;
    check_eq("nop_first_req", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 12'h000}));
    step();
    check_eq("nop_pc_after_ack", 64'(pc), 64'h001);
    check_eq("nop_no_pulses", 64'({exec_en, ld_en, illegal_op}), 64'h0);

    // ADD with three wait states
    mem[0] = 32'h5000_0000;
    fixed_delay = 3;
    start();
    n = 0;
    while (mem_req && n < 10) begin
      check_eq("add_wait_addr", 64'({mem_we, mem_addr}), 64'h000);
      n++;
      step();
    end
    check_eq("add_req_cycles", 64'(n), 64'd4);
    check_eq("add_exec_decode", 64'(exec_en), 64'h1);
    step();
    check_eq("add_exec_once", 64'(exec_en), 64'h0);
    fixed_delay = 0;

    // LOAD from memory then STORE
    clear_mem();
    mem[0] = 32'h1000_5003;
    mem[1] = 32'h2000_7009;
    mem[5] = 32'hDEAD_BEEF;
    start();
    step();
    step();
    check_eq("load_rd_req", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 12'h005}));
    step();
    check_eq("load_ld_en", 64'(ld_en), 64'h1);
    check_eq("load_ld_data", 64'(ld_data), 64'hDEAD_BEEF);
    step();
    check_eq("load_ld_en_once", 64'(ld_en), 64'h0);
    step();
    check_eq("store_wr_req", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b1, 12'h009}));
    check_eq("store_wdata", 64'(mem_wdata), 64'h1234_5678);

    // Branch: every code against every flag value
    clear_mem();
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < 32; p++) begin
        ins = 32'h3000_0040 | (32'(c) << 12);
        mem[0] = ins;
        psr_force = 5'(p);
        start();
        step();
        step();
        exp_pc = br_ref(3'(c), 5'(p)) ? 12'h040 : 12'h001;
        check_eq($sformatf("branch_c%0d_p%0d", c, p), 64'(mem_addr), 64'(exp_pc));
      end
    end
    psr_force = '0;

    // PC wrap at the top of the address space
    clear_mem();
    mem[0] = 32'h3000_0FFF;
    start();
    step();
    step();
    check_eq("wrap_fetch_fff", 64'(mem_addr), 64'hFFF);
    step();
    check_eq("wrap_pc_zero", 64'(pc), 64'h000);
    step();
    check_eq("wrap_fetch_zero", 64'({mem_req, mem_addr}), 64'({1'b1, 12'h000}));

    // Undefined opcode
    clear_mem();
    mem[0] = 32'hC000_0000;
    start();
    step();
    check_eq("illegal_pulse", 64'({illegal_op, exec_en}), 64'b10);
    step();
    check_eq("illegal_once", 64'(illegal_op), 64'h0);
    check_eq("illegal_next_fetch", 64'({mem_req, mem_addr}), 64'({1'b1, 12'h001}));

    // HALT
    clear_mem();
    mem[0] = 32'h8000_0000;
    start();
    step();
    step();
    check_eq("halt_flag", 64'(halted), 64'h1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req) cnt++;
    end
    check_eq("halt_no_req", 64'(cnt), 64'd0);
    check_eq("halt_pc_frozen", 64'(pc), 64'h001);

    // Reset while a store waits for ack
    clear_mem();
    mem[0] = 32'h2000_0009;
    start();
    step();
    ack_block = 1'b1;
    step();
    check_eq("abort_wr_req", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b1, 12'h009}));
    step();
    check_eq("abort_wr_wait", 64'(mem_req), 64'h1);
    reset = 1'b1;
    force_ack = 1'b1;
    #1;
    check_eq("abort_req_in_reset", 64'(mem_req), 64'h0);
    step();
    check_eq("abort_pc_reset", 64'(pc), 64'h000);
    check_eq("abort_req_held_low", 64'(mem_req), 64'h0);
    step();
    reset = 1'b0;
    force_ack = 1'b0;
    ack_block = 1'b0;
    #1;
    check_eq("abort_refetch", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 12'h000}));
    step();
    check_eq("abort_ir", 64'(ir), 64'h2000_0009);
    check_eq("abort_pc_after", 64'(pc), 64'h001);

    // Randomized programs against the instruction-level model
    psr_force_en = 1'b0;
    rand_delay = 1'b1;
    for (int run = 0; run < 6; run++) begin
      gen_program();
      build_expected(80);
      start();
      n = exp_q.size();
      cyc = 0;
      while (act_q.size() < n && cyc < 4000) begin
        step();
        cyc++;
      end
      check_eq($sformatf("rand%0d_evcount", run), 64'(act_q.size() >= n), 64'd1);
      for (int i = 0; i < n; i++) begin
        if (i < act_q.size())
          check_eq($sformatf("rand%0d_ev%0d", run, i), 64'(act_q[i]), 64'(exp_q[i]));
      end
      if (exp_q[n-1].kind == EV_HLT) begin
        repeat (5) step();
        check_eq($sformatf("rand%0d_halt_quiet", run), 64'(act_q.size()), 64'(n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
